// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Iteration counter width; never let it collapse to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division iteration
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    // rem < dvs on entry, so t - dvs always fits back into WIDTH bits.
    always_comb begin
        t        = {rem, dvd_msb};
        q_bit    = (t >= {1'b0, dvs});
        rem_next = q_bit ? WIDTH'(t - {1'b0, dvs}) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider; SEQ_DIVIDER_SIGNED_EN selects two's complement operands
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
`endif

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;

    seq_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    // State register; reset drops any in-flight operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus datapath next values: accept, iterate, then publish results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    dvd_d   = A[WIDTH-1] ? -A : A;
                    dvs_d   = B[WIDTH-1] ? -B : B;
                    a_neg_d = A[WIDTH-1];
                    b_neg_d = B[WIDTH-1];
`else
                    dvd_d   = A;
                    dvs_d   = B;
`endif
                    rem_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = (dvd_q << 1) | WIDTH'(step_qbit);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dvs_q == '0) begin
                    // No iterations ran, so dvd still holds the (magnitude of the) dividend.
                    q_d   = '1;
                    dbz_d = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    r_d   = a_neg_q ? -dvd_q : dvd_q;
`else
                    r_d   = dvd_q;
`endif
                end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    q_d   = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
                    r_d   = a_neg_q ? -rem_q : rem_q;
`else
                    q_d   = dvd_q;
                    r_d   = rem_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
`endif
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - table-driven and scoreboarded bench for seq_divider
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t sb[$];
    vec_t tbl[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai, bi, qi, ri;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
            return e;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        ai = $signed(a);
        bi = $signed(b);
`else
        ai = int'(a);
        bi = int'(b);
`endif
        qi = ai / bi;
        ri = ai % bi;
        e.q = qi[W-1:0]; e.r = ri[W-1:0]; e.dbz = 1'b0;
        return e;
    endfunction

    function automatic void add(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
        tbl.push_back(v);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("Q", Q, e.q);
                check("R", R, e.r);
                check("div_by_zero", div_by_zero, e.dbz);
            end
        end
    end

    // Called at a negedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_start", busy, 0);
        A = a; B = b; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        check("busy_after_accept", busy, 1);
        check("dbz_clear_on_accept", div_by_zero, 0);
    endtask

    // Waits for the done pulse, then returns at the following negedge.
    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", done, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        int k;

`ifdef SEQ_DIVIDER_SIGNED_EN
        add(8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0);
        add(8'd7,  8'hFE, 8'hFD, 8'h01, 1'b0);
        add(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        add(8'd13, 8'd0,  8'hFF, 8'd13, 1'b1);
        add(8'd9,  8'd3,  8'd3,  8'd0,  1'b0);
        add(8'hF3, 8'd0,  8'hFF, 8'hF3, 1'b1);
        add(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0);
        add(8'd100,8'hF9, 8'hF2, 8'h02, 1'b0);
        add(8'h80, 8'h01, 8'h80, 8'h00, 1'b0);
        add(8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0);
        add(8'h80, 8'h80, 8'h01, 8'h00, 1'b0);
`else
        add(8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        add(8'd13,  8'd0,   8'hFF,  8'd13,  1'b1);
        add(8'd9,   8'd3,   8'd3,   8'd0,   1'b0);
        add(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        add(8'd0,   8'd5,   8'd0,   8'd0,   1'b0);
        add(8'd200, 8'd9,   8'd22,  8'd2,   1'b0);
        add(8'd1,   8'd255, 8'd0,   8'd1,   1'b0);
        add(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
        add(8'd254, 8'd255, 8'd0,   8'd254, 1'b0);
        add(8'd128, 8'd2,   8'd64,  8'd0,   1'b0);
        add(8'd255, 8'd16,  8'd15,  8'd15,  1'b0);
        add(8'd0,   8'd0,   8'hFF,  8'd0,   1'b1);
        add(8'd7,   8'd8,   8'd0,   8'd7,   1'b0);
`endif

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_Q", Q, 0);
        check("rst_R", R, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);

        // 100/7 latency profile with an ignored start pulse at N+3
        @(negedge clk);
        issue(8'd100, 8'd7, model(8'd100, 8'd7));
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                @(negedge clk);
                start = 1'b1; A = 8'd50; B = 8'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_during_run", busy, 1);
            check("done_low_during_run", done, 0);
        end
        @(posedge clk); #1;
        check("done_at_n9", done, 1);
        check("busy_low_at_n9", busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("ignored_start_not_run", busy, 0);
        @(negedge clk);

        // Table vectors
        foreach (tbl[i]) begin
            exp_t e;
            e.q = tbl[i].q; e.r = tbl[i].r; e.dbz = tbl[i].dbz;
            issue(tbl[i].a, tbl[i].b, e);
            wait_done();
        end

        // start held high: second op accepted on the first IDLE cycle after done
        A = 8'd255; B = 8'd1; start = 1'b1;
        sb.push_back(model(8'd255, 8'd1));
        k = 0;
        @(negedge clk);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("held_first_done", done, 1);
        A = 8'd0; B = 8'd5;
        sb.push_back(model(8'd0, 8'd5));
        @(posedge clk); #1;
        check("held_second_accepted", busy, 1);
        start = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of 200/9
        issue(8'd200, 8'd9, model(8'd200, 8'd9));
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_Q", Q, 0);
        check("async_rst_R", R, 0);
        check("async_rst_done", done, 0);
        check("async_rst_dbz", div_by_zero, 0);
        sb.delete();
        n_before = n_done;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        check("no_done_after_reset", n_done, n_before);
        issue(8'd200, 8'd9, model(8'd200, 8'd9));
        wait_done();

        // Random operands against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 5 == 4) ? '0 : W'($urandom);
            issue(ra, rb, model(ra, rb));
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
